// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: issue, operand and write-back bundle between the pipeline and fwd_hazard_unit.
// The stall_cnt/fwd_cnt members exist only when FWD_HAZARD_STATS_EN is defined.
interface fwd_hazard_if #(
  parameter int XLEN         = 32,
  parameter int NUM_RD_PORTS = 2
);
  logic                         clkEn;
  logic                         stall_ext;
  logic                         flush;
  logic                         iss_valid;
  logic [4:0]                   iss_rd;
  logic                         iss_wen;
  logic                         iss_is_load;
  logic [5*NUM_RD_PORTS-1:0]    iss_rs;
  logic [NUM_RD_PORTS-1:0]      iss_rs_used;
  logic [XLEN-1:0]              res_data;
  logic [XLEN-1:0]              ld_data;
  logic [XLEN*NUM_RD_PORTS-1:0] rf_data;
  logic [XLEN*NUM_RD_PORTS-1:0] opnd;
  logic                         hazard_stall;
  logic                         wb_en;
  logic [4:0]                   wb_addr;
  logic [XLEN-1:0]              wb_data;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]                  stall_cnt;
  logic [31:0]                  fwd_cnt;

  modport master (
    output clkEn, stall_ext, flush, iss_valid, iss_rd, iss_wen, iss_is_load,
           iss_rs, iss_rs_used, res_data, ld_data, rf_data,
    input  opnd, hazard_stall, wb_en, wb_addr, wb_data, stall_cnt, fwd_cnt
  );

  modport slave (
    input  clkEn, stall_ext, flush, iss_valid, iss_rd, iss_wen, iss_is_load,
           iss_rs, iss_rs_used, res_data, ld_data, rf_data,
    output opnd, hazard_stall, wb_en, wb_addr, wb_data, stall_cnt, fwd_cnt
  );
`else
  modport master (
    output clkEn, stall_ext, flush, iss_valid, iss_rd, iss_wen, iss_is_load,
           iss_rs, iss_rs_used, res_data, ld_data, rf_data,
    input  opnd, hazard_stall, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  clkEn, stall_ext, flush, iss_valid, iss_rd, iss_wen, iss_is_load,
           iss_rs, iss_rs_used, res_data, ld_data, rf_data,
    output opnd, hazard_stall, wb_en, wb_addr, wb_data
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: in-flight result tracker giving operand forwarding, load-use stall and RF write-back.
// Define FWD_HAZARD_STATS_EN to add saturating stall_cnt/fwd_cnt activity counters.
module fwd_hazard_unit #(
  parameter int XLEN         = 32,
  parameter int NUM_STAGES   = 2,
  parameter int NUM_RD_PORTS = 2,
  parameter int LOAD_STAGE   = 1
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);
  localparam int LAST = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] wen_q, wen_d;
  logic [NUM_STAGES-1:0] is_load_q, is_load_d;
  logic [NUM_STAGES-1:0] ready_q, ready_d;
  logic [4:0]            rd_q   [NUM_STAGES];
  logic [4:0]            rd_d   [NUM_STAGES];
  logic [XLEN-1:0]       data_q [NUM_STAGES];
  logic [XLEN-1:0]       data_d [NUM_STAGES];

  logic                         adv;
  logic                         issue;
  logic                         any_haz;
  logic                         stall_c;
  logic [NUM_RD_PORTS-1:0]      port_haz;
  logic [XLEN-1:0]              port_val [NUM_RD_PORTS];
  logic [XLEN*NUM_RD_PORTS-1:0] opnd_c;
`ifdef FWD_HAZARD_STATS_EN
  logic [NUM_RD_PORTS-1:0]      port_fwd;
  logic                         any_fwd;
`endif

  assign adv = bus.clkEn & ~bus.stall_ext;

  // Entries are scanned oldest first so the youngest matching producer is the last to overwrite.
  always_comb begin
    any_haz = 1'b0;
    opnd_c  = '0;
`ifdef FWD_HAZARD_STATS_EN
    any_fwd = 1'b0;
`endif
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      port_haz[p] = 1'b0;
      port_val[p] = bus.rf_data[XLEN*p +: XLEN];
`ifdef FWD_HAZARD_STATS_EN
      port_fwd[p] = 1'b0;
`endif
      for (int k = LAST; k >= 0; k--) begin
        if (valid_q[k] && wen_q[k] && (rd_q[k] != 5'd0) &&
            (rd_q[k] == bus.iss_rs[5*p +: 5]) && bus.iss_rs_used[p]) begin
          port_haz[p] = 1'b0;
          port_val[p] = bus.rf_data[XLEN*p +: XLEN];
`ifdef FWD_HAZARD_STATS_EN
          port_fwd[p] = 1'b1;
`endif
          if (ready_q[k]) begin
            port_val[p] = data_q[k];
          end else if (k == LOAD_STAGE) begin
            port_val[p] = bus.ld_data;
          end else if (k < LOAD_STAGE) begin
            port_haz[p] = 1'b1;
`ifdef FWD_HAZARD_STATS_EN
            port_fwd[p] = 1'b0;
`endif
          end
        end
      end
      opnd_c[XLEN*p +: XLEN] = port_val[p];
      any_haz = any_haz | port_haz[p];
`ifdef FWD_HAZARD_STATS_EN
      any_fwd = any_fwd | port_fwd[p];
`endif
    end
  end

  assign stall_c = adv & bus.iss_valid & ~bus.flush & any_haz & ~rst;
  assign issue   = bus.iss_valid & ~bus.flush & ~stall_c;

  // A load leaving LOAD_STAGE picks up ld_data on its way into the next entry.
  always_comb begin
    valid_d   = valid_q;
    wen_d     = wen_q;
    is_load_d = is_load_q;
    ready_d   = ready_q;
    rd_d      = rd_q;
    data_d    = data_q;
    if (adv) begin
      for (int k = LAST; k >= 1; k--) begin
        valid_d[k]   = valid_q[k-1];
        wen_d[k]     = wen_q[k-1];
        is_load_d[k] = is_load_q[k-1];
        ready_d[k]   = ready_q[k-1];
        rd_d[k]      = rd_q[k-1];
        data_d[k]    = data_q[k-1];
        if ((k - 1 == LOAD_STAGE) && is_load_q[k-1] && !ready_q[k-1]) begin
          ready_d[k] = 1'b1;
          data_d[k]  = bus.ld_data;
        end
      end
      valid_d[0]   = issue;
      wen_d[0]     = bus.iss_wen;
      is_load_d[0] = bus.iss_is_load;
      ready_d[0]   = ~bus.iss_is_load;
      rd_d[0]      = bus.iss_rd;
      data_d[0]    = bus.res_data;
      if ((LOAD_STAGE == 0) && bus.iss_is_load) begin
        ready_d[0] = 1'b1;
        data_d[0]  = bus.ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      wen_q     <= '0;
      is_load_q <= '0;
      ready_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      is_load_q <= is_load_d;
      ready_q   <= ready_d;
    end
  end

  // Payload fields are only meaningful alongside valid, so they carry no reset.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  assign bus.opnd         = opnd_c;
  assign bus.hazard_stall = stall_c;
  assign bus.wb_en        = adv & valid_q[LAST] & wen_q[LAST] & (rd_q[LAST] != 5'd0) & ~rst;
  assign bus.wb_addr      = rd_q[LAST];
  assign bus.wb_data      = ((LOAD_STAGE == LAST) && is_load_q[LAST] && !ready_q[LAST]) ?
                            bus.ld_data : data_q[LAST];

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (adv && issue && any_fwd && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scenario tasks for a default fwd_hazard_unit and a 4-stage/3-port variant,
// with write-back checked against queues of expected register writes.
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  localparam logic [31:0] RF0  = 32'h0F0F_0001;
  localparam logic [31:0] RF1  = 32'h0F0F_0002;
  localparam logic [31:0] RF40 = 32'hA0A0_0001;
  localparam logic [31:0] RF41 = 32'hA1A1_0002;
  localparam logic [31:0] RF42 = 32'hA2A2_0003;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  wb_t  exp_q[$];
  wb_t  exp4_q[$];
  wb_t  mon_e;
  wb_t  mon4_e;

  fwd_hazard_if #(.XLEN(32), .NUM_RD_PORTS(2)) bus ();
  fwd_hazard_if #(.XLEN(32), .NUM_RD_PORTS(3)) bus4 ();

  fwd_hazard_unit #(.XLEN(32), .NUM_STAGES(2), .NUM_RD_PORTS(2), .LOAD_STAGE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fwd_hazard_unit #(.XLEN(32), .NUM_STAGES(4), .NUM_RD_PORTS(3), .LOAD_STAGE(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(negedge clk) begin
    if (bus.wb_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL wb_unexpected: addr=%0d data=%h, required no write", bus.wb_addr, bus.wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.wb_addr !== mon_e.addr || bus.wb_data !== mon_e.data) begin
          failures++;
          $display("[TB] FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.wb_addr, bus.wb_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.wb_en === 1'b1) begin
      checks++;
      if (exp4_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL wb4_unexpected: addr=%0d data=%h, required no write", bus4.wb_addr, bus4.wb_data);
      end else begin
        mon4_e = exp4_q.pop_front();
        if (bus4.wb_addr !== mon4_e.addr || bus4.wb_data !== mon4_e.data) begin
          failures++;
          $display("[TB] FAIL wb4_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus4.wb_addr, bus4.wb_data, mon4_e.addr, mon4_e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                       input logic [31:0] res);
    bus.iss_valid   = v;
    bus.iss_rd      = rd;
    bus.iss_wen     = wen;
    bus.iss_is_load = ld;
    bus.iss_rs      = {rs1, rs0};
    bus.iss_rs_used = used;
    bus.res_data    = res;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 32'h0);
    bus.flush     = 1'b0;
    bus.stall_ext = 1'b0;
    bus.ld_data   = 32'h0;
    bus.rf_data   = {RF1, RF0};
  endtask

  task automatic idle4();
    bus4.iss_valid   = 1'b0;
    bus4.iss_rd      = 5'd0;
    bus4.iss_wen     = 1'b0;
    bus4.iss_is_load = 1'b0;
    bus4.iss_rs      = '0;
    bus4.iss_rs_used = '0;
    bus4.res_data    = 32'h0;
    bus4.flush       = 1'b0;
    bus4.stall_ext   = 1'b0;
    bus4.ld_data     = 32'h0;
    bus4.rf_data     = {RF42, RF41, RF40};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 32'h44);
    @(negedge clk);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b required 0", bus.hazard_stall); end
    checks++;
    if (bus.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_en: got %b required 0", bus.wb_en); end
    cyc();
    rst = 1'b0;
    drive(1'b1, 5'd4, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11, 32'h44);
    @(negedge clk);
    checks++;
    if (bus.opnd !== {RF1, RF0}) begin failures++; $display("[TB] FAIL reset_opnd: got %h required %h", bus.opnd, {RF1, RF0}); end
    checks++;
    if (bus4.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb4_en: got %b required 0", bus4.wb_en); end
    cyc();
    idle();
    cyc();
  endtask

  task automatic test_forward();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'h11);
    exp_q.push_back({5'd5, 32'h11});
    cyc();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd5, 2'b11, 32'h22);
    exp_q.push_back({5'd6, 32'h22});
    @(negedge clk);
    checks++;
    if (bus.opnd !== {32'h11, 32'h11}) begin failures++; $display("[TB] FAIL fwd_entry0: got %h required %h", bus.opnd, {32'h11, 32'h11}); end
    checks++;
    if (bus.hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL fwd_stall: got %b required 0", bus.hazard_stall); end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'h11) begin
      failures++;
      $display("[TB] FAIL fwd_wb: got en=%b addr=%0d data=%h required en=1 addr=5 data=00000011", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL fwd_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 32'h999);
    exp_q.push_back({5'd7, 32'hDEADBEEF});
    cyc();
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b11, 32'h88);
    @(negedge clk);
    checks++;
    if (bus.hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall: got %b required 1", bus.hazard_stall); end
    cyc();
    bus.ld_data = 32'hDEADBEEF;
    exp_q.push_back({5'd8, 32'h88});
    @(negedge clk);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL lu_one_stall: got %b required 0", bus.hazard_stall); end
    checks++;
    if (bus.opnd !== {RF1, 32'hDEADBEEF}) begin failures++; $display("[TB] FAIL lu_opnd: got %h required %h", bus.opnd, {RF1, 32'hDEADBEEF}); end
    cyc();
    idle();
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL lu_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'hA);
    exp_q.push_back({5'd3, 32'hA});
    cyc();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'hB);
    exp_q.push_back({5'd3, 32'hB});
    cyc();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd3, 2'b01, 32'hC);
    exp_q.push_back({5'd9, 32'hC});
    @(negedge clk);
    checks++;
    if (bus.opnd !== {RF1, 32'hB}) begin failures++; $display("[TB] FAIL prio_youngest: got %h required %h", bus.opnd, {RF1, 32'hB}); end
    cyc();
    drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'h55);
    cyc();
    bus.rf_data = '0;
    drive(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.opnd !== 64'h0) begin failures++; $display("[TB] FAIL prio_x0: got %h required 0", bus.opnd); end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if (bus.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL prio_x0_wb: got %b required 0", bus.wb_en); end
    cyc();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL prio_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_holds();
    drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'h1111);
    exp_q.push_back({5'd11, 32'h1111});
    cyc();
    drive(1'b1, 5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 32'h0);
    exp_q.push_back({5'd12, 32'hCAFEF00D});
    cyc();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd12, 5'd0, 2'b01, 32'h13);
    bus.stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.hazard_stall !== 1'b0 || bus.wb_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_frozen: got stall=%b wb_en=%b required 0/0 in hold cycle %0d", bus.hazard_stall, bus.wb_en, i);
      end
      cyc();
    end
    bus.stall_ext = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL hold_resume_stall: got %b required 1", bus.hazard_stall); end
    cyc();
    bus.ld_data = 32'hCAFEF00D;
    exp_q.push_back({5'd13, 32'h13});
    @(negedge clk);
    checks++;
    if (bus.hazard_stall !== 1'b0 || bus.opnd[31:0] !== 32'hCAFEF00D) begin
      failures++;
      $display("[TB] FAIL hold_resume_opnd: got stall=%b opnd0=%h required 0/cafef00d", bus.hazard_stall, bus.opnd[31:0]);
    end
    cyc();
    idle();
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL hold_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd14, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 32'h0);
    exp_q.push_back({5'd14, 32'h1414});
    cyc();
    drive(1'b1, 5'd15, 1'b1, 1'b0, 5'd14, 5'd0, 2'b01, 32'h15);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall: got %b required 0", bus.hazard_stall); end
    cyc();
    idle();
    bus.ld_data = 32'h1414;
    cyc();
    bus.ld_data = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL flush_bubble_wb: got %b required 0", bus.wb_en); end
    cyc();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL flush_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd20, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'h20);
    cyc();
    drive(1'b1, 5'd21, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 32'h21);
    cyc();
    rst = 1'b1;
    drive(1'b1, 5'd22, 1'b0, 1'b0, 5'd20, 5'd21, 2'b11, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_wb_during: got %b required 0", bus.wb_en); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_en !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_wb_after: got %b required 0", bus.wb_en); end
    checks++;
    if (bus.opnd !== {RF1, RF0}) begin failures++; $display("[TB] FAIL rstmid_opnd: got %h required %h", bus.opnd, {RF1, RF0}); end
    cyc();
    idle();
    cyc();
  endtask

  task automatic test_param();
    bus4.iss_valid   = 1'b1;
    bus4.iss_rd      = 5'd7;
    bus4.iss_wen     = 1'b1;
    bus4.iss_is_load = 1'b1;
    exp4_q.push_back({5'd7, 32'h4444});
    cyc();
    bus4.iss_rd      = 5'd8;
    bus4.iss_is_load = 1'b0;
    bus4.iss_rs      = {5'd7, 5'd0, 5'd7};
    bus4.iss_rs_used = 3'b101;
    bus4.res_data    = 32'h88;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus4.hazard_stall !== 1'b1) begin failures++; $display("[TB] FAIL param_stall: got %b required 1 in stall cycle %0d", bus4.hazard_stall, i); end
      cyc();
    end
    bus4.ld_data = 32'h4444;
    exp4_q.push_back({5'd8, 32'h88});
    @(negedge clk);
    checks++;
    if (bus4.hazard_stall !== 1'b0) begin failures++; $display("[TB] FAIL param_release: got %b required 0", bus4.hazard_stall); end
    checks++;
    if (bus4.opnd !== {32'h4444, RF41, 32'h4444}) begin
      failures++;
      $display("[TB] FAIL param_opnd: got %h required %h", bus4.opnd, {32'h4444, RF41, 32'h4444});
    end
    cyc();
    idle4();
`ifdef FWD_HAZARD_STATS_EN
    @(negedge clk);
    checks++;
    if (bus4.stall_cnt !== 32'd2) begin failures++; $display("[TB] FAIL param_stall_cnt: got %0d required 2", bus4.stall_cnt); end
    checks++;
    if (bus4.fwd_cnt !== 32'd1) begin failures++; $display("[TB] FAIL param_fwd_cnt: got %0d required 1", bus4.fwd_cnt); end
`endif
    repeat (6) cyc();
    checks++;
    if (exp4_q.size() != 0) begin failures++; $display("[TB] FAIL param_drain: got %0d pending required 0", exp4_q.size()); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.clkEn  = 1'b1;
    bus4.clkEn = 1'b1;
    idle();
    idle4();
    test_reset();
    test_forward();
    test_load_use();
    test_priority();
    test_holds();
    test_flush();
    test_reset_mid();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
